// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch types and constants
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory and decode-side signals of the fetch stage
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_ready;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [31:0]        instr_pc;
  logic [31:0]        pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  id_ready,
    output instr_valid, instr, instr_pc, pc_plus4
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output id_ready,
    input  instr_valid, instr, instr_pc, pc_plus4
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry {pc, instr} queue between fetch and decode
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: 32'h0, instr: NOP_INSTR};
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && !clear && count == FULL));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && !clear && count == '0));

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC-driven imem req/ack fetch with a small instruction queue
// Optional misaligned-PC halt under FETCH_MISALIGN_CHK_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_in,
  output logic          pc_write,
  input  logic          flush,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic          fetch_misalign,
`endif
  fetch_stage_if.master fetch_bus
);

  localparam logic [1:0] IDLE  = 2'(FETCH_IDLE);
  localparam logic [1:0] WAIT  = 2'(FETCH_WAIT);
  localparam logic [1:0] DRAIN = 2'(FETCH_DRAIN);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]   state;
  logic [AW:0]  count;
  logic         has_room;
  logic         halt;
  logic         issue;
  logic         accept;
  logic         pop;
  fetch_entry_t push_data;
  fetch_entry_t head;

  assign has_room = (count < FULL);

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned_pc;
  assign misaligned_pc = (pc_in[1:0] != 2'b00);
  assign halt          = fetch_misalign | misaligned_pc;

  // Sticky until a redirect supplies a new PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_misalign <= 1'b0;
    end else if (flush) begin
      fetch_misalign <= 1'b0;
    end else if (state == IDLE && has_room && misaligned_pc) begin
      fetch_misalign <= 1'b1;
    end
  end
`else
  assign halt = 1'b0;
`endif

  assign issue    = (state == IDLE) && !flush && has_room && !halt;
  assign accept   = (state == WAIT) && fetch_bus.imem_ack && !flush;
  assign pc_write = flush | accept;
  assign pop      = fetch_bus.instr_valid && fetch_bus.id_ready && !flush;

  // An ack always retires the outstanding request; only a flush without one
  // leaves a stale response in flight that DRAIN must swallow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      fetch_bus.imem_req  <= 1'b0;
      fetch_bus.imem_addr <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            fetch_bus.imem_req  <= 1'b1;
            fetch_bus.imem_addr <= pc_in;
            state               <= WAIT;
          end
        end
        WAIT: begin
          if (fetch_bus.imem_ack) begin
            fetch_bus.imem_req <= 1'b0;
            state              <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fetch_bus.imem_ack) begin
            fetch_bus.imem_req <= 1'b0;
            state              <= IDLE;
          end
        end
        default: begin
          fetch_bus.imem_req <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

  assign push_data = '{pc: fetch_bus.imem_addr, instr: fetch_bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .pop       (pop),
    .clear     (flush),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign fetch_bus.instr_valid = (count != '0);
  assign fetch_bus.instr       = head.instr;
  assign fetch_bus.instr_pc    = head.pc;
  assign fetch_bus.pc_plus4    = head.pc + 32'd4;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, runs a req/ack transaction with instruction memory, and buffers returned {pc, instr} pairs in a small queue feeding the IF/ID boundary.
- Drives the PC register's write enable, so the PC advances only when an instruction is accepted or on a redirect (flush).

Parameters:
- DEPTH, 2, queue entries; power of two, >=2.
- AW, $clog2(DEPTH), queue pointer width (derived).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pc_in  input  32  current PC (PC register output)
- pc_write  output  1  write enable to PC register (combinational)
- imem_req  output  1  instruction-memory request (registered)
- imem_addr  output  32  request address (registered, held while imem_req=1)
- imem_ack  input  1  memory response valid; one-cycle pulse
- imem_rdata  input  32  instruction word, valid with imem_ack
- flush  input  1  redirect (taken branch/jump); pc_in already carries target mux select
- id_ready  input  1  decode can accept (low = stall)
- instr_valid  output  1  queue head valid
- instr  output  32  queue head instruction
- instr_pc  output  32  queue head PC
- pc_plus4  output  32  instr_pc + 4, modulo 2^32

Behaviour:
- Reset (async) sets: state IDLE, imem_req=0, imem_addr=0, queue empty (instr_valid=0), instr/instr_pc=0.
- Reset mid-transaction abandons the request. Memory must tolerate an abandoned request.
- FSM states:
  - IDLE: if !flush && count<DEPTH, then at the edge imem_req<=1, imem_addr<=pc_in, state->WAIT. Otherwise stay.
  - WAIT: on imem_ack && !flush, at the edge: push {imem_addr, imem_rdata}, imem_req<=0, state->IDLE. On flush (with or without ack): clear queue, state->DRAIN if no ack this cycle, else ->IDLE with the response discarded; imem_req<=0 in the ->IDLE case only.
  - DRAIN: imem_req held 1 until ack. On ack, discard data, imem_req<=0, ->IDLE. A flush while in DRAIN keeps it in DRAIN.
- pc_write = flush | (state==WAIT && imem_ack && !flush). Exactly one PC advance per accepted instruction.
- Throughput: at most 1 instruction per 2 cycles (IDLE issue, ack at earliest the next cycle).
- Queue:
  - instr_valid = (count!=0).
  - pop = instr_valid && id_ready && !flush.
  - Push and pop in the same cycle: count unchanged, ordering preserved.
  - Overflow is impossible because issue requires count<DEPTH. This is checked by assertion.
  - Pointers wrap modulo DEPTH.
- Flush: clears the queue the same edge, so instr_valid=0 next cycle. Takes priority over push and pop.
- Head outputs are combinational from the queue head. Their value is don't-care when instr_valid=0.

Optional Feature:
- Macro FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - In IDLE, if pc_in[1:0]!=0 and issue is otherwise allowed: no request is issued, fetch_misalign<=1 (sticky), and fetching halts.
  - flush clears fetch_misalign and resumes.
- Undefined: no port, no check; pc_in is used unmodified.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum {IDLE, WAIT, DRAIN}
  - constant INSTR_W=32
  - constant NOP_INSTR=32'h0000_0000
- One natural sub-module: fetch_fifo (parameterised DEPTH×64-bit synchronous FIFO with push, pop, clear, count, head).

Test Plan:
- Reset then pc_in=0x0, ack 1 cycle after each req, id_ready=1 -> imem_addr 0x0,0x4,0x8 on successive requests; instr_valid with instr_pc=0x0, pc_plus4=0x4; one pc_write pulse per ack.
- id_ready=0 for 10 cycles -> queue fills to 2; imem_req stays 0 with count=2; pc_write=0; releasing id_ready pops in order 0x0, 0x4.
- Flush during WAIT with ack 3 cycles later -> DRAIN; data discarded (never visible); pc_write=1 on the flush cycle only; next request addr = redirected pc_in (e.g. 0x100).
- Flush coincident with ack and id_ready pop -> queue empty next cycle; no push; pc_write=1 once.
- Async reset asserted while imem_req=1 -> imem_req=0 and instr_valid=0 immediately (before next edge).
- (FETCH_MISALIGN_CHK_EN) pc_in=0x102 -> no imem_req; fetch_misalign=1 until flush with pc_in=0x104, then a request to 0x104.
